// File: rtl/unified_mem_responder_if.sv
// Request/response bundle between the pipeline IF/MEM stages and unified_mem_responder.
// Optional MEM_MISALIGN_TRAP_EN adds the d_misalign response flag.
interface unified_mem_responder_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        busy;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        d_misalign;

  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
    input  if_ready, if_rdata, d_ready, d_rdata, busy, d_misalign
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
    output if_ready, if_rdata, d_ready, d_rdata, busy, d_misalign
  );
`else
  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
    input  if_ready, if_rdata, d_ready, d_rdata, busy
  );
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
    output if_ready, if_rdata, d_ready, d_rdata, busy
  );
`endif
endinterface

// File: rtl/unified_mem_responder.sv
// Single-ported unified I/D memory responder: fetch/data arbitration, wait states, byte-lane access.
// Optional MEM_MISALIGN_TRAP_EN: misaligned data accesses are suppressed and flagged on d_misalign.
module unified_mem_responder #(
  parameter int    DEPTH       = 64,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic clk,
  input  logic rst,
  unified_mem_responder_if.slave bus
);
  // state | meaning
  // IDLE  | no transaction; a pending request is granted and latched
  // WAIT  | wait-state down-counter running to terminal count 0
  // RESP  | ready/rdata flops valid for this cycle; no new grant

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]   r_mem [DEPTH];
  logic [3:0]    r_cnt;
  logic          r_last_was_data;
  logic          r_is_data;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_if_ready;
  logic          r_d_ready;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic          w_any_req;
  logic          w_pick_data;
  logic          w_grant;
  logic          w_enter_resp;
  logic          w_acc_data;
  logic          w_acc_we;
  logic [2:0]    w_acc_f3;
  logic [AW+1:0] w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_wr_data;
  logic [3:0]    w_be;
  logic          w_misal;
  logic          w_trap;
  logic          w_unused;

  assign w_any_req   = bus.if_req | bus.d_req;
  // Data normally wins; a data grant last time hands priority to fetch.
  assign w_pick_data = bus.d_req & (~bus.if_req | ~r_last_was_data);
  assign w_grant     = (r_state == IDLE) & w_any_req;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == RESP);

  // With zero wait states RESP is entered straight from IDLE, so the grant values feed the access.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_data  = w_pick_data;
      w_acc_we    = w_pick_data & bus.d_we;
      w_acc_f3    = w_pick_data ? bus.d_funct3 : 3'b010;
      w_acc_addr  = w_pick_data ? bus.d_addr[AW+1:0] : bus.if_addr[AW+1:0];
      w_acc_wdata = bus.d_wdata;
    end else begin
      w_acc_data  = r_is_data;
      w_acc_we    = r_we;
      w_acc_f3    = r_funct3;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
  end

  assign w_idx  = w_acc_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_acc_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{w_acc_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_be      = 4'b1111;
    w_wr_data = w_acc_wdata;
    w_load    = w_word;
    w_misal   = 1'b0;
    case (w_acc_f3)
      3'b000: begin
        w_be      = 4'b0001 << w_acc_addr[1:0];
        w_wr_data = {4{w_acc_wdata[7:0]}};
        w_load    = {{24{w_byte[7]}}, w_byte};
      end
      3'b001: begin
        w_be      = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{w_acc_wdata[15:0]}};
        w_load    = {{16{w_half[15]}}, w_half};
        w_misal   = w_acc_addr[0];
      end
      3'b100: begin
        if (!w_acc_we) w_load  = {24'd0, w_byte};
        else           w_misal = |w_acc_addr[1:0];
      end
      3'b101: begin
        if (!w_acc_we) begin
          w_load  = {16'd0, w_half};
          w_misal = w_acc_addr[0];
        end else begin
          w_misal = |w_acc_addr[1:0];
        end
      end
      default: w_misal = |w_acc_addr[1:0];
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap         = w_acc_data & w_misal;
  assign bus.d_misalign = r_misalign;

  always_ff @(posedge clk) begin
    if (rst)               r_misalign <= 1'b0;
    else if (w_enter_resp) r_misalign <= w_trap;
    else                   r_misalign <= 1'b0;
  end
`else
  assign w_trap = 1'b0;
`endif

  assign w_unused = ^{bus.if_addr[31:AW+2], bus.d_addr[31:AW+2], w_misal};

  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_acc_data && w_acc_we && !w_trap) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= 4'd0;
      r_last_was_data <= 1'b0;
      r_is_data       <= 1'b0;
      r_we            <= 1'b0;
      r_funct3        <= 3'd0;
      r_addr          <= '0;
      r_wdata         <= 32'd0;
      r_if_ready      <= 1'b0;
      r_d_ready       <= 1'b0;
      r_if_rdata      <= 32'd0;
      r_d_rdata       <= 32'd0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      if (w_grant) begin
        r_is_data       <= w_pick_data;
        r_last_was_data <= w_pick_data;
        r_we            <= w_acc_we;
        r_funct3        <= w_acc_f3;
        r_addr          <= w_acc_addr;
        r_wdata         <= w_acc_wdata;
        r_cnt           <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        if (w_acc_data) begin
          r_d_ready <= 1'b1;
          r_d_rdata <= (w_acc_we | w_trap) ? 32'd0 : w_load;
        end else begin
          r_if_ready <= 1'b1;
          r_if_rdata <= w_word;
        end
      end
    end
  end

  assign bus.if_ready = r_if_ready;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_ready  = r_d_ready;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.busy     = (r_state != IDLE);
endmodule
